lelbc_iter_ctrl: RTL and testbench

//  Iterative LELBC encryption controller: accepts a 64-bit block and 128-bit key, then drives the

---
 rtl/lelbc_iter_ctrl.sv | 131 +++++++++++++
 tb/tb_lelbc_iter_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lelbc_iter_ctrl.sv
// Iterative LELBC encryption controller.
// Accepts a 64-bit block and a 128-bit key, then runs the external combinational
// round function once per clock for NR rounds. The round state and key are
// registered between rounds, and the ciphertext is returned over a valid/ready
// handshake.
//
// Optional feature macro: LELBC_FINAL_WHITEN_EN
//   When defined, the ciphertext is XORed with the upper 64 bits of the final
//   round key.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/ready    plaintext and key handshake
//   in_data, in_key   plaintext [0:63] and master key [0:127]; bit 0 is the MSB
//   out_valid/ready   ciphertext handshake
//   out_data          ciphertext [0:63]
//   rf_in/key/cnt     state register, key register and round index, fed to the round function
//   rf_result         combinational data result from the round function
//   rf_key_result     combinational updated key from the round function
module lelbc_iter_ctrl #(
    parameter int unsigned NR    = 25,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:63]      in_data,
    input  logic [0:127]     in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:63]      out_data,
    output logic [0:63]      rf_in,
    output logic [0:127]     rf_key,
    output logic [CNT_W-1:0] rf_cnt,
    input  logic [0:63]      rf_result,
    input  logic [0:127]     rf_key_result
);

    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NR - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [0:63]      state_q, state_qn;
    logic [0:127]     key_q, key_qn;
    logic [CNT_W-1:0] rnd_q, rnd_qn;
    logic             in_ready_n, out_valid_n;
    logic [0:63]      out_data_n;
    logic [0:63]      final_data;

    // Ciphertext as it will appear in DONE, formed from the last round's outputs.
`ifdef LELBC_FINAL_WHITEN_EN
    assign final_data = rf_result ^ rf_key_result[0:63];
`else
    assign final_data = rf_result;
`endif

    assign rf_in  = state_q;
    assign rf_key = key_q;
    assign rf_cnt = rnd_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            state_q   <= '0;
            key_q     <= '0;
            rnd_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            state_q   <= state_qn;
            key_q     <= key_qn;
            rnd_q     <= rnd_qn;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        state_qn   = state_q;
        key_qn     = key_q;
        rnd_qn     = rnd_q;
        out_data_n = out_data;

        case (state)
            IDLE: begin
                // Gate on the registered ready, which stays low in the cycle right after reset.
                if (in_valid && in_ready) begin
                    state_qn = in_data;
                    key_qn   = in_key;
                    rnd_qn   = '0;
                    state_n  = RUN;
                end
            end
            RUN: begin
                state_qn = rf_result;
                key_qn   = rf_key_result;
                if (rnd_q == LAST_RND) begin
                    // The final round is captured here; the index holds rather than wrapping.
                    out_data_n = final_data;
                    state_n    = DONE;
                end else begin
                    rnd_qn = rnd_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n  = (state_n == IDLE);
        out_valid_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_lelbc_iter_ctrl.sv
// Directed and randomised bench for lelbc_iter_ctrl.
// A simple stand-in round function is modelled here. It drives the DUT's rf_*
// inputs, and the same function is iterated to produce the expected ciphertext.
module tb_lelbc_iter_ctrl;

    localparam int unsigned NR    = 25;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [0:63]      in_data;
    logic [0:127]     in_key;
    logic             out_valid;
    logic             out_ready;
    logic [0:63]      out_data;
    logic [0:63]      rf_in;
    logic [0:127]     rf_key;
    logic [CNT_W-1:0] rf_cnt;
    logic [0:63]      rf_result;
    logic [0:127]     rf_key_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lelbc_iter_ctrl #(.NR(NR), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_key       (in_key),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .rf_in        (rf_in),
        .rf_key       (rf_key),
        .rf_cnt       (rf_cnt),
        .rf_result    (rf_result),
        .rf_key_result(rf_key_result)
    );

    // Stand-in round function: rotate, XOR with the upper key half and the round index, then add a constant.
    function automatic logic [63:0] rnd_data(input logic [63:0] s, input logic [127:0] k, input logic [4:0] c);
        logic [63:0] t;
        t = {s[50:0], s[63:51]} ^ k[127:64] ^ {59'd0, c};
        return t + 64'h9E3779B97F4A7C15;
    endfunction

    // Stand-in key schedule: rotate the key, then XOR the round index into the low bits.
    function automatic logic [127:0] rnd_key(input logic [127:0] k, input logic [4:0] c);
        return {k[66:0], k[127:67]} ^ {123'd0, c};
    endfunction

    assign rf_result     = rnd_data(rf_in, rf_key, rf_cnt);
    assign rf_key_result = rnd_key(rf_key, rf_cnt);

    // Expected ciphertext for one block.
    function automatic logic [63:0] model(input logic [63:0] d, input logic [127:0] k);
        logic [63:0]  s;
        logic [127:0] kk;
        s  = d;
        kk = k;
        for (int r = 0; r < int'(NR); r++) begin
            s  = rnd_data(s, kk, 5'(r));
            kk = rnd_key(kk, 5'(r));
        end
`ifdef LELBC_FINAL_WHITEN_EN
        s = s ^ kk[127:64];
`endif
        return s;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one block end to end, checking every cycle.
    // stall: number of extra cycles DONE is held with out_ready low.
    // hold: keep in_valid high with different data while the block is being processed.
    task automatic run_block(input logic [63:0] d, input logic [127:0] k, input int stall, input bit hold);
        logic [63:0] exp;
        int          n;
        exp = model(d, k);
        n   = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("accept_ready", 128'(in_ready), 128'(1));
        in_data   = d;
        in_key    = k;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();  // accept edge E0
        if (hold) begin
            in_data = ~d;
            in_key  = ~k;
        end else begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
        end
        for (int c = 0; c < int'(NR); c++) begin
            check_eq("rf_cnt", 128'(rf_cnt), 128'(c));
            check_eq("run_out_valid", 128'(out_valid), 128'(0));
            check_eq("run_in_ready", 128'(in_ready), 128'(0));
            tick();
        end
        check_eq("done_out_valid", 128'(out_valid), 128'(1));
        check_eq("done_out_data", 128'(out_data), 128'(exp));
        for (int s = 0; s < stall; s++) begin
            tick();
            check_eq("stall_out_valid", 128'(out_valid), 128'(1));
            check_eq("stall_out_data", 128'(out_data), 128'(exp));
            check_eq("stall_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();  // drain edge
        check_eq("drain_out_valid", 128'(out_valid), 128'(0));
        check_eq("drain_in_ready", 128'(in_ready), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_out_data", 128'(out_data), 128'(0));
        check_eq("rst_rf_cnt", 128'(rf_cnt), 128'(0));
        check_eq("rst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        tick();
        check_eq("post_rst_in_ready", 128'(in_ready), 128'(1));

        // All-zero vector with out_ready held high.
        run_block(64'h0, 128'h0, 0, 1'b0);

        // Known vector, stalled 10 cycles in DONE.
        run_block(64'h0123456789ABCDEF, 128'h00112233445566778899AABBCCDDEEFF, 10, 1'b0);

        // in_valid held high throughout. The second block is accepted right after the drain.
        run_block(64'hDEADBEEFCAFEF00D, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 2, 1'b1);
        run_block(64'h1122334455667788, 128'hFFEEDDCCBBAA99887766554433221100, 0, 1'b0);

        // Reset mid-run at round index 7.
        in_data  = 64'hAAAA5555AAAA5555;
        in_key   = 128'h1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("pre_rst_rf_cnt", 128'(rf_cnt), 128'(7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
        check_eq("midrst_rf_cnt", 128'(rf_cnt), 128'(0));
        check_eq("midrst_rf_in", 128'(rf_in), 128'(0));
        check_eq("midrst_out_data", 128'(out_data), 128'(0));
        for (int i = 0; i < int'(NR) + 3; i++) begin
            tick();
            check_eq("midrst_no_valid", 128'(out_valid), 128'(0));
        end
        run_block(64'h0, 128'h0, 0, 1'b0);

        // Random blocks with random output back-pressure.
        for (int b = 0; b < 100; b++) begin
            run_block({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
